rom_reader: RTL and testbench

Sequential read initiator for the 16-word × 16-bit combinational ROM. On a start request it sweeps a contiguous, wrap-around range of ROM addresses. It registers each returned word and delivers it downstream over a valid/ready stream, then pulses `done`. It sits between control logic and the ROM, replacing hand-driven address stepping.

---
 rtl/rom_pkg.sv | 15 +
 rtl/rom_reader_csum.sv | 32 +++
 rtl/rom_reader.sv | 104 ++++++++++
 tb/tb_rom_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the 16x16 ROM and its sequential reader.
// State encoding and default geometry are common to both blocks.
package rom_pkg;

    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } rom_state_e;

endpackage

// File: rtl/rom_reader_csum.sv
// Running-sum accumulator for rom_reader; only built when ROM_READER_CSUM_EN is defined.
// Sum wraps modulo 2^DATA_W; clear has priority over enable.
`ifdef ROM_READER_CSUM_EN
module rom_reader_csum
    import rom_pkg::*;
#(
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (enable) begin
            sum_q <= sum_q + data;
        end
    end

    assign sum = sum_q;

endmodule
`endif

// File: rtl/rom_reader.sv
// Sequential read initiator: sweeps a wrap-around ROM address range and streams words out.
// Define ROM_READER_CSUM_EN to build the per-sweep checksum accumulator; otherwise checksum is 0.
module rom_reader
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] FULL_SWEEP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_WORD  = (ADDR_W+1)'(1);

    rom_state_e        state_q;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    logic accept;
    logic xfer;

    assign accept = (state_q == IDLE) && start;
    assign xfer   = (state_q == SEND) && out_valid_q && out_ready;

    // One extra bit on the remaining counter so count==0 can mean a full 2^ADDR_W sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rom_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rom_addr_q  <= base_addr;
                        remaining_q <= (count == '0) ? FULL_SWEEP : {1'b0, count};
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    out_data_q  <= rom_data;
                    out_valid_q <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        out_valid_q <= 1'b0;
                        if (remaining_q == LAST_WORD) begin
                            state_q <= DONE;
                        end else begin
                            remaining_q <= remaining_q - LAST_WORD;
                            rom_addr_q  <= rom_addr_q + ADDR_W'(1);
                            state_q     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

`ifdef ROM_READER_CSUM_EN
    rom_reader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (xfer),
        .data   (out_data_q),
        .sum    (checksum)
    );
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader: stimulus queues expected words, a negedge monitor checks them.
// Reference ROM is word[a] = 16'h0F00 + a.
module tb_rom_reader;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  base_addr;
    logic [3:0]  count;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int          checkCount = 0;
    int          passCount  = 0;
    exp_t        expQ[$];
    logic [15:0] expSum;

    logic        prevValid;
    logic        prevReady;
    logic        prevDone;
    logic [15:0] prevData;
    logic [3:0]  prevAddr;

    rom_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    assign rom_data = 16'h0F00 + {12'h000, rom_addr};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability and done behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prevValid = 1'b0;
            prevReady = 1'b0;
            prevDone  = 1'b0;
        end else begin
            if (prevValid && !prevReady) begin
                checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("stall_data", {16'd0, out_data}, {16'd0, prevData});
                checkOutput("stall_addr", {28'd0, rom_addr}, {28'd0, prevAddr});
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("word_data", {16'd0, out_data}, {16'd0, e.data});
                    checkOutput("word_addr", {28'd0, rom_addr}, {28'd0, e.addr});
                end
            end
            if (done) begin
                checkOutput("done_single", {31'd0, prevDone}, 32'd0);
                checkOutput("done_queue_empty", expQ.size(), 32'd0);
`ifdef ROM_READER_CSUM_EN
                checkOutput("checksum", {16'd0, checksum}, {16'd0, expSum});
`else
                checkOutput("checksum", {16'd0, checksum}, 32'd0);
`endif
            end
            prevValid = out_valid;
            prevReady = out_ready;
            prevDone  = done;
            prevData  = out_data;
            prevAddr  = rom_addr;
        end
    end

    // Runs one sweep; stallCycles holds ready low first, midStart pokes start mid-sweep and in DONE,
    // resetAt (>0) aborts the sweep with a reset after that many cycles.
    task automatic applyStimulus(input logic [3:0] base, input logic [3:0] cnt, input int readyPct,
                                 input int stallCycles, input bit midStart, input int resetAt);
        int   k;
        int   cycles;
        bit   seen;
        bit   aborted;
        exp_t e;
        k      = (cnt == 4'd0) ? 16 : int'(cnt);
        expSum = 16'h0000;
        for (int i = 0; i < k; i++) begin
            e.addr = base + 4'(i);
            e.data = 16'h0F00 + {12'h000, e.addr};
            expSum = expSum + e.data;
            expQ.push_back(e);
        end
        start     = 1'b1;
        base_addr = base;
        count     = cnt;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 4'($urandom);
        count     = 4'($urandom);
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("rom_addr_base", {28'd0, rom_addr}, {28'd0, base});
        cycles  = 0;
        seen    = 1'b0;
        aborted = 1'b0;
        while (!seen && cycles < 2000) begin
            if (resetAt > 0 && cycles == resetAt) begin
                rst_n = 1'b0;
                start = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                expQ.delete();
                checkOutput("rst_busy", {31'd0, busy}, 32'd0);
                checkOutput("rst_done", {31'd0, done}, 32'd0);
                checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
                checkOutput("rst_addr", {28'd0, rom_addr}, 32'd0);
                checkOutput("rst_data", {16'd0, out_data}, 32'd0);
                checkOutput("rst_checksum", {16'd0, checksum}, 32'd0);
                aborted = 1'b1;
                break;
            end
            out_ready = (cycles < stallCycles) ? 1'b0 : ($urandom_range(0, 99) < readyPct);
            if (midStart && cycles == 3) begin
                start     = 1'b1;
                base_addr = 4'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!aborted) begin
            if (!seen) begin
                checkOutput("done_timeout", 32'd0, 32'd1);
            end else begin
                if (readyPct == 100 && stallCycles == 0) begin
                    checkOutput("done_latency", cycles, 2 * k);
                end
                if (midStart) begin
                    start     = 1'b1;
                    base_addr = 4'd9;
                end
                @(posedge clk); #1;
                start = 1'b0;
                checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
                checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
                checkOutput("queue_drained", expQ.size(), 32'd0);
            end
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        base_addr = 4'd0;
        count     = 4'd0;
        @(posedge clk); #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_addr", {28'd0, rom_addr}, 32'd0);
        checkOutput("reset_data", {16'd0, out_data}, 32'd0);
        checkOutput("reset_checksum", {16'd0, checksum}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(4'd3, 4'd2, 100, 0, 1'b0, 0);
        applyStimulus(4'd14, 4'd4, 100, 0, 1'b0, 0);
        applyStimulus(4'd5, 4'd3, 100, 6, 1'b0, 0);
        applyStimulus(4'd0, 4'd0, 100, 0, 1'b0, 0);
        applyStimulus(4'd2, 4'd6, 100, 0, 1'b1, 0);
        applyStimulus(4'd7, 4'd8, 100, 0, 1'b0, 5);
        applyStimulus(4'd1, 4'd3, 100, 0, 1'b0, 0);
        for (int r = 0; r < 8; r++) begin
            applyStimulus(4'($urandom), 4'($urandom), int'($urandom_range(40, 100)), 0, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
